// File: rtl/sha256_block_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : sha256_block_loader_if
// Summary   : message-word input stream and digest output handshake
// Revision  : 1.0  initial release
// ============================================================================
interface sha256_block_loader_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [255:0] m_digest;

  // master = host side (produces words, consumes digest); slave = loader
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_digest);
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_digest);
endinterface
`default_nettype wire

// File: rtl/sha256_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : sha256_block_loader
// Summary  : loads padded 512-bit blocks into the sha256 core, issues init/next,
//            polls STATUS and returns the 256-bit digest on a handshake.
// Revision : 1.0  initial release
// ============================================================================
module sha256_block_loader #(
  parameter int POST_CTRL_WAIT = 2,
  parameter int POLL_LIMIT     = 4096
) (
  input  wire                   clk,
  input  wire                   reset,
  sha256_block_loader_if.slave  strm,
  output logic                  busy,
  output logic                  err,
  output logic                  core_cs,
  output logic                  core_we,
  output logic [7:0]            core_address,
  output logic [31:0]           core_write_data,
  input  wire  [31:0]           core_read_data,
  input  wire                   core_error
);
  localparam logic [7:0] c_addr_ctrl   = 8'h08;
  localparam logic [7:0] c_addr_status = 8'h09;
  localparam int         c_wait_w      = $clog2(POST_CTRL_WAIT + 1);
  localparam int         c_poll_w      = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CTRL, S_WAIT, S_POLL, S_DIG, S_OUT
  } state_t;

  state_t                r_state, w_state_nx;
  logic [3:0]            r_idx, w_idx_nx;
  logic [c_wait_w-1:0]   r_wait_cnt, w_wait_nx;
  logic [c_poll_w-1:0]   r_poll_cnt, w_poll_nx;
  logic [2:0]            r_dig_idx, w_dig_nx;
  logic                  r_first_blk, w_first_nx;
  logic                  r_last_blk, w_last_nx;
  logic                  w_cs_nx, w_we_nx;
  logic [7:0]            w_addr_nx;
  logic [31:0]           w_wdata_nx;
  logic                  w_timeout, w_capture, w_accept;
  logic [255:0]          r_digest;

  assign strm.s_ready  = (r_state == S_LOAD);
  assign strm.m_valid  = (r_state == S_OUT);
  assign strm.m_digest = r_digest;
  assign busy          = (r_state != S_IDLE);
  assign w_accept      = strm.s_valid && strm.s_ready;

  // Bus signals computed here describe the access on the following cycle.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_wait_nx  = r_wait_cnt;
    w_poll_nx  = r_poll_cnt;
    w_dig_nx   = r_dig_idx;
    w_first_nx = r_first_blk;
    w_last_nx  = r_last_blk;
    w_cs_nx    = 1'b0;
    w_we_nx    = 1'b0;
    w_addr_nx  = 8'h00;
    w_wdata_nx = 32'h0;
    w_timeout  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (strm.s_valid) begin
          w_state_nx = S_LOAD;
          w_idx_nx   = 4'd0;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_cs_nx    = 1'b1;
          w_we_nx    = 1'b1;
          w_addr_nx  = {4'h1, r_idx};
          w_wdata_nx = strm.s_data;
          if (r_idx == 4'd15) begin
            w_last_nx  = strm.s_last;
            w_state_nx = S_CTRL;
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end
      end
      S_CTRL: begin
        w_cs_nx    = 1'b1;
        w_we_nx    = 1'b1;
        w_addr_nx  = c_addr_ctrl;
        w_wdata_nx = r_first_blk ? 32'h5 : 32'h6;
        w_first_nx = 1'b0;
        w_wait_nx  = '0;
        w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        // The CTRL write occupies the first WAIT cycle, then the idle gap follows.
        if (r_wait_cnt == c_wait_w'(POST_CTRL_WAIT)) begin
          w_cs_nx    = 1'b1;
          w_addr_nx  = c_addr_status;
          w_poll_nx  = '0;
          w_state_nx = S_POLL;
        end else begin
          w_wait_nx = r_wait_cnt + c_wait_w'(1);
        end
      end
      S_POLL: begin
        w_poll_nx = r_poll_cnt + c_poll_w'(1);
        if (core_read_data[0]) begin
          if (r_last_blk) begin
            w_cs_nx    = 1'b1;
            w_addr_nx  = 8'h20;
            w_dig_nx   = 3'd0;
            w_state_nx = S_DIG;
          end else begin
            w_idx_nx   = 4'd0;
            w_poll_nx  = '0;
            w_state_nx = S_LOAD;
          end
        end else if (r_poll_cnt == c_poll_w'(POLL_LIMIT - 1)) begin
          w_timeout  = 1'b1;
          w_first_nx = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_cs_nx   = 1'b1;
          w_addr_nx = c_addr_status;
        end
      end
      S_DIG: begin
        w_capture = 1'b1;
        if (r_dig_idx == 3'd7) begin
          w_state_nx = S_OUT;
        end else begin
          w_dig_nx  = r_dig_idx + 3'd1;
          w_cs_nx   = 1'b1;
          w_addr_nx = {5'b00100, w_dig_nx};
        end
      end
      S_OUT: begin
        if (strm.m_ready) begin
          w_first_nx = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_idx           <= 4'd0;
      r_wait_cnt      <= '0;
      r_poll_cnt      <= '0;
      r_dig_idx       <= 3'd0;
      r_first_blk     <= 1'b1;
      r_last_blk      <= 1'b0;
      r_digest        <= '0;
      err             <= 1'b0;
      core_cs         <= 1'b0;
      core_we         <= 1'b0;
      core_address    <= 8'h00;
      core_write_data <= 32'h0;
    end else begin
      r_state         <= w_state_nx;
      r_idx           <= w_idx_nx;
      r_wait_cnt      <= w_wait_nx;
      r_poll_cnt      <= w_poll_nx;
      r_dig_idx       <= w_dig_nx;
      r_first_blk     <= w_first_nx;
      r_last_blk      <= w_last_nx;
      err             <= err | core_error | w_timeout;
      core_cs         <= w_cs_nx;
      core_we         <= w_we_nx;
      core_address    <= w_addr_nx;
      core_write_data <= w_wdata_nx;
      if (w_capture) begin
        r_digest[(7 - int'(r_dig_idx)) * 32 +: 32] <= core_read_data;
      end
    end
  end
endmodule
`default_nettype wire
